// File: rtl/brz_slice_sync.sv
// brz_slice_sync: clocked bit-slice handshake stage.
// Pulls a word from a four-phase producer, keeps the selected bit field in a
// one-entry buffer, and hands it to a four-phase consumer. With PREFETCH set,
// the buffer refills as soon as it empties, so a waiting word is delivered one
// cycle after the consumer requests it.
module brz_slice_sync #(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 16,
    parameter int LOW_INDEX    = 1,
    parameter int PREFETCH     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    out_0r,
    output logic                    out_0a,
    output logic [OUTPUT_WIDTH-1:0] out_0d,
    output logic                    inp_0r,
    input  logic                    inp_0a,
    input  logic [INPUT_WIDTH-1:0]  inp_0d
);

    // The selected field must fit entirely inside the input word.
    if (LOW_INDEX < 0 || LOW_INDEX + OUTPUT_WIDTH > INPUT_WIDTH) begin : g_bad_slice
        $error("brz_slice_sync: LOW_INDEX + OUTPUT_WIDTH exceeds INPUT_WIDTH");
    end

    localparam bit PREFETCH_EN = (PREFETCH != 0);

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_REQ,
        IN_RTZ
    } in_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_ACK
    } out_state_t;

    in_state_t               in_state_q, in_state_d;
    out_state_t              out_state_q, out_state_d;
    logic                    full_q, full_d;
    logic [OUTPUT_WIDTH-1:0] buf_q, buf_d;
    logic                    inp_0r_d;
    logic                    out_0a_d;

    // Bits outside the field are deliberately discarded.
    logic unused_inp_bits;
    assign unused_inp_bits = ^inp_0d;

    // The buffer is only written while empty, so it is stable while out_0a is high.
    assign out_0d = buf_q;

    // Next-state and next-output logic for both handshake FSMs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        full_d      = full_q;
        buf_d       = buf_q;
        inp_0r_d    = inp_0r;
        out_0a_d    = out_0a;

        // Producer side: fetch when empty and either prefetching or the consumer waits.
        case (in_state_q)
            IN_IDLE: begin
                if (!full_q && (PREFETCH_EN || (out_0r && !out_0a))) begin
                    inp_0r_d   = 1'b1;
                    in_state_d = IN_REQ;
                end
            end
            IN_REQ: begin
                if (inp_0a) begin
                    buf_d      = inp_0d[LOW_INDEX +: OUTPUT_WIDTH];
                    full_d     = 1'b1;
                    inp_0r_d   = 1'b0;
                    in_state_d = IN_RTZ;
                end
            end
            IN_RTZ: begin
                if (!inp_0a) begin
                    in_state_d = IN_IDLE;
                end
            end
            default: begin
                in_state_d = IN_IDLE;
            end
        endcase

        // Consumer side: acknowledge a request once the buffer holds data, then
        // free the buffer when the request returns to zero. Setting and clearing
        // full are mutually exclusive (one needs full low, the other full high).
        case (out_state_q)
            OUT_IDLE: begin
                if (out_0r && full_q) begin
                    out_0a_d    = 1'b1;
                    out_state_d = OUT_ACK;
                end
            end
            OUT_ACK: begin
                if (!out_0r) begin
                    out_0a_d    = 1'b0;
                    full_d      = 1'b0;
                    out_state_d = OUT_IDLE;
                end
            end
            default: begin
                out_state_d = OUT_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides any handshake in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            full_q      <= 1'b0;
            buf_q       <= '0;
            inp_0r      <= 1'b0;
            out_0a      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            full_q      <= full_d;
            buf_q       <= buf_d;
            inp_0r      <= inp_0r_d;
            out_0a      <= out_0a_d;
        end
    end

endmodule

// File: tb/tb_brz_slice_sync.sv
// Directed testbench for brz_slice_sync: one instance without prefetch (u0)
// and one with prefetch (u1), sharing clock and reset.
module tb_brz_slice_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        out0_r = 1'b0, out0_a;
    logic [15:0] out0_d;
    logic        inp0_r, inp0_a = 1'b0;
    logic [17:0] inp0_d = '0;

    logic        out1_r = 1'b0, out1_a;
    logic [15:0] out1_d;
    logic        inp1_r, inp1_a = 1'b0;
    logic [17:0] inp1_d = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    brz_slice_sync #(.INPUT_WIDTH(18), .OUTPUT_WIDTH(16), .LOW_INDEX(1), .PREFETCH(0)) u0 (
        .clk    (clk),
        .rst    (rst),
        .out_0r (out0_r),
        .out_0a (out0_a),
        .out_0d (out0_d),
        .inp_0r (inp0_r),
        .inp_0a (inp0_a),
        .inp_0d (inp0_d)
    );

    brz_slice_sync #(.INPUT_WIDTH(18), .OUTPUT_WIDTH(16), .LOW_INDEX(1), .PREFETCH(1)) u1 (
        .clk    (clk),
        .rst    (rst),
        .out_0r (out1_r),
        .out_0a (out1_a),
        .out_0d (out1_d),
        .inp_0r (inp1_r),
        .inp_0a (inp1_a),
        .inp_0d (inp1_d)
    );

    // Advance one rising edge and settle; inputs driven here are seen at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        out0_r = 1'b0; inp0_a = 1'b0; inp0_d = '0;
        out1_r = 1'b0; inp1_a = 1'b0; inp1_d = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One consumer transaction on u0 with a producer that acks in the same cycle.
    task automatic run_fetch0(input logic [17:0] word, input logic [15:0] exp, input string tag);
        out0_r = 1'b1;
        tick();
        checks++;
        if (inp0_r !== 1'b1 || out0_a !== 1'b0) begin
            errors++;
            $display("FAIL %s req: inp_0r=%b out_0a=%b expected 1/0", tag, inp0_r, out0_a);
        end
        inp0_a = 1'b1;
        inp0_d = word;
        tick();
        checks++;
        if (inp0_r !== 1'b0 || out0_a !== 1'b0) begin
            errors++;
            $display("FAIL %s capture: inp_0r=%b out_0a=%b expected 0/0", tag, inp0_r, out0_a);
        end
        inp0_a = 1'b0;
        tick();
        checks++;
        if (out0_a !== 1'b1 || out0_d !== exp) begin
            errors++;
            $display("FAIL %s ack: out_0a=%b out_0d=%h expected 1/%h", tag, out0_a, out0_d, exp);
        end
        out0_r = 1'b0;
        tick();
        checks++;
        if (out0_a !== 1'b0 || inp0_r !== 1'b0) begin
            errors++;
            $display("FAIL %s release: out_0a=%b inp_0r=%b expected 0/0", tag, out0_a, inp0_r);
        end
    endtask

    task automatic test_reset();
        out0_r = 1'b1; inp0_a = 1'b1; inp0_d = '1;
        out1_r = 1'b1; inp1_a = 1'b1; inp1_d = '1;
        rst = 1'b1;
        tick();
        checks++;
        if ({out0_a, inp0_r, out1_a, inp1_r} !== 4'b0000 || out0_d !== 16'h0000 || out1_d !== 16'h0000) begin
            errors++;
            $display("FAIL reset: a/r=%b%b%b%b d0=%h d1=%h expected 0000/0000/0000",
                     out0_a, inp0_r, out1_a, inp1_r, out0_d, out1_d);
        end
        tick();
        checks++;
        if ({out0_a, inp0_r, out1_a, inp1_r} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: a/r=%b%b%b%b expected 0000", out0_a, inp0_r, out1_a, inp1_r);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_basic();
        run_fetch0(18'h2AAAB, 16'h5555, "basic");
    endtask

    task automatic test_boundary();
        run_fetch0(18'h20001, 16'h0000, "field_low");
        run_fetch0(18'h3FFFE, 16'hFFFF, "field_high");
    endtask

    task automatic test_prefetch();
        do_reset();
        tick();
        checks++;
        if (inp1_r !== 1'b1 || out1_a !== 1'b0) begin
            errors++;
            $display("FAIL pf_req: inp_0r=%b out_0a=%b expected 1/0", inp1_r, out1_a);
        end
        inp1_a = 1'b1;
        inp1_d = 18'h00246;
        tick();
        checks++;
        if (inp1_r !== 1'b0) begin
            errors++;
            $display("FAIL pf_capture: inp_0r=%b expected 0", inp1_r);
        end
        inp1_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inp1_r !== 1'b0 || out1_a !== 1'b0) begin
                errors++;
                $display("FAIL pf_single_pulse[%0d]: inp_0r=%b out_0a=%b expected 0/0", i, inp1_r, out1_a);
            end
        end
        out1_r = 1'b1;
        tick();
        checks++;
        if (out1_a !== 1'b1 || out1_d !== 16'h0123) begin
            errors++;
            $display("FAIL pf_ack: out_0a=%b out_0d=%h expected 1/0123", out1_a, out1_d);
        end
        out1_r = 1'b0;
        tick();
        checks++;
        if (out1_a !== 1'b0 || inp1_r !== 1'b0) begin
            errors++;
            $display("FAIL pf_release: out_0a=%b inp_0r=%b expected 0/0", out1_a, inp1_r);
        end
        tick();
        checks++;
        if (inp1_r !== 1'b1) begin
            errors++;
            $display("FAIL pf_refetch: inp_0r=%b expected 1", inp1_r);
        end
    endtask

    task automatic test_slow_producer();
        out0_r = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (inp0_r !== 1'b1 || out0_a !== 1'b0) begin
                errors++;
                $display("FAIL slow_wait[%0d]: inp_0r=%b out_0a=%b expected 1/0", i, inp0_r, out0_a);
            end
        end
        inp0_a = 1'b1;
        inp0_d = 18'h1ACF0;
        tick();
        inp0_d = 18'h3FFFF;
        tick();
        checks++;
        if (out0_a !== 1'b1 || out0_d !== 16'hD678 || inp0_r !== 1'b0) begin
            errors++;
            $display("FAIL slow_ack: out_0a=%b out_0d=%h inp_0r=%b expected 1/d678/0", out0_a, out0_d, inp0_r);
        end
        out0_r = 1'b0;
        tick();
        out0_r = 1'b1;
        tick();
        tick();
        checks++;
        if (out0_d !== 16'hD678 || inp0_r !== 1'b0 || out0_a !== 1'b0) begin
            errors++;
            $display("FAIL slow_no_recapture: out_0d=%h inp_0r=%b out_0a=%b expected d678/0/0", out0_d, inp0_r, out0_a);
        end
        inp0_a = 1'b0;
        tick();
        checks++;
        if (inp0_r !== 1'b0) begin
            errors++;
            $display("FAIL slow_rtz: inp_0r=%b expected 0", inp0_r);
        end
        tick();
        checks++;
        if (inp0_r !== 1'b1) begin
            errors++;
            $display("FAIL slow_next_req: inp_0r=%b expected 1", inp0_r);
        end
        inp0_a = 1'b1;
        inp0_d = 18'h00002;
        tick();
        inp0_a = 1'b0;
        tick();
        checks++;
        if (out0_a !== 1'b1 || out0_d !== 16'h0001) begin
            errors++;
            $display("FAIL slow_second: out_0a=%b out_0d=%h expected 1/0001", out0_a, out0_d);
        end
        out0_r = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        // u1 is left in IN_REQ by the prefetch test; finish its fetch, then hold it in OUT_ACK.
        inp1_a = 1'b1;
        inp1_d = 18'h3FFFF;
        out0_r = 1'b1;
        tick();
        inp1_a = 1'b0;
        out1_r = 1'b1;
        tick();
        checks++;
        if (out1_a !== 1'b1 || out1_d !== 16'hFFFF || inp0_r !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: out1_a=%b out1_d=%h inp0_r=%b expected 1/ffff/1", out1_a, out1_d, inp0_r);
        end
        inp0_a = 1'b1; inp1_a = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if ({out0_a, inp0_r, out1_a, inp1_r} !== 4'b0000 || out0_d !== 16'h0000 || out1_d !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: a/r=%b%b%b%b d0=%h d1=%h expected 0000/0000/0000",
                     out0_a, inp0_r, out1_a, inp1_r, out0_d, out1_d);
        end
        rst = 1'b0;
        clear_inputs();
        tick();
        run_fetch0(18'h0FFFE, 16'h7FFF, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_prefetch();
        test_slow_producer();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
